// File: rtl/seller_pkg.sv
// Shared definitions for the seller vending-machine controller.
// Holds the FSM state encoding, coin unit values and the system clock rate.
// Coin-to-unit conversion is kept here so every user agrees on the weighting.
package seller_pkg;

  typedef enum logic [1:0] {
    COLLECT  = 2'd0,
    DISPENSE = 2'd1,
    PAYOUT   = 2'd2
  } state_t;

  localparam int HALF_UNIT = 1;
  localparam int ONE_UNIT  = 2;
  localparam int CLK_HZ    = 50_000_000;

  // Units credited for the coin pulses seen in one cycle (0..3).
  function automatic logic [1:0] coin_units(input logic half, input logic one);
    logic [1:0] u;
    u = 2'd0;
    if (half) u = u + 2'(HALF_UNIT);
    if (one)  u = u + 2'(ONE_UNIT);
    return u;
  endfunction

endpackage

// File: rtl/seller_payout.sv
// Pacer for change/refund pulses: a load starts a GAP-1 cycle quiet period.
// Latency: o_busy rises the cycle after i_load and falls GAP-1 cycles later.
// Backpressure: none; a load while busy simply restarts the gap.
module seller_payout
  import seller_pkg::*;
#(
  parameter int GAP = 25_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_load,
  output logic o_busy
);

  // Sized so GAP-1 always fits, including GAP == 1.
  localparam int CW = $clog2(GAP + 1);

  logic [CW-1:0] r_gap_cnt;

  // Load the gap on a pulse, otherwise count down to zero and rest there.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gap_cnt <= '0;
    end else if (i_load) begin
      r_gap_cnt <= CW'(GAP - 1);
    end else if (r_gap_cnt != '0) begin
      r_gap_cnt <= r_gap_cnt - CW'(1);
    end
  end

  assign o_busy = (r_gap_cnt != '0);

endmodule

// File: rtl/seller_ctrl.sv
// Vending transaction controller: collect coins, dispense via timer, pay change.
// Latency: every output is registered, one cycle after the inputs that cause it.
// Backpressure: coins outside COLLECT (or overflowing MAX_BAL) are rejected.
module seller_ctrl
  import seller_pkg::*;
#(
  parameter int PRICE   = 5,
  parameter int MAX_BAL = 15,
  parameter int BAL_W   = 4,
  parameter int GAP     = 25_000_000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             coin_half,
  input  logic             coin_one,
  input  logic             cancel,
  input  logic             t_end,
  output logic             t_rst_n,
  output logic             dispense,
  output logic             change_pulse,
  output logic             coin_reject,
  output logic [BAL_W-1:0] balance,
  output logic             busy
);

  // Overflow test is done two bits wider so balance + 3 can never wrap,
  // even for a parameter set where BAL_W only just holds MAX_BAL.
  localparam logic [BAL_W+1:0] LP_MAX_W   = (BAL_W + 2)'(MAX_BAL);
  localparam logic [BAL_W+1:0] LP_PRICE_W = (BAL_W + 2)'(PRICE);
  localparam logic [BAL_W-1:0] LP_PRICE   = BAL_W'(PRICE);

  state_t           r_state, w_state_nxt;
  logic [BAL_W-1:0] r_balance, w_bal_nxt;
  logic             r_t_rst_n, w_trst_nxt;
  logic             r_dispense, w_disp_nxt;
  logic             r_change, w_chg_nxt;
  logic             r_reject, w_rej_nxt;
  logic             r_busy;
  logic             r_first, w_first_nxt;
  logic             w_load;
  logic             w_pace_busy;
  logic [1:0]       w_add;
  logic [BAL_W-1:0] w_nb;
  logic [BAL_W+1:0] w_nb_wide;
  logic             w_any_coin;

  assign w_add      = coin_units(coin_half, coin_one);
  assign w_any_coin = coin_half | coin_one;
  assign w_nb       = r_balance + BAL_W'(w_add);
  assign w_nb_wide  = {2'b00, r_balance} + {{BAL_W{1'b0}}, w_add};

  seller_payout #(.GAP(GAP)) u_payout (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_load (w_load),
    .o_busy (w_pace_busy)
  );

  // Next state and next registered outputs; everything holds unless changed.
  always_comb begin
    w_state_nxt = r_state;
    w_bal_nxt   = r_balance;
    w_trst_nxt  = r_t_rst_n;
    w_disp_nxt  = r_dispense;
    w_chg_nxt   = 1'b0;
    w_rej_nxt   = 1'b0;
    w_first_nxt = 1'b0;
    w_load      = 1'b0;
    unique case (r_state)
      COLLECT: begin
        if ((w_add != 2'd0) && (w_nb_wide > LP_MAX_W)) begin
          w_rej_nxt = 1'b1;
        end else if (cancel && (w_nb != '0)) begin
          // Refund takes priority even if this coin reached the price.
          w_bal_nxt   = w_nb;
          w_state_nxt = PAYOUT;
        end else if (w_nb_wide >= LP_PRICE_W) begin
          w_bal_nxt   = w_nb - LP_PRICE;
          w_state_nxt = DISPENSE;
          w_trst_nxt  = 1'b0;
          w_disp_nxt  = 1'b1;
          w_first_nxt = 1'b1;
        end else begin
          w_bal_nxt = w_nb;
        end
      end
      DISPENSE: begin
        w_rej_nxt = w_any_coin;
        // The timer still shows its previous t_end on our first cycle.
        if (!r_first && t_end) begin
          w_trst_nxt  = 1'b1;
          w_disp_nxt  = 1'b0;
          w_state_nxt = (r_balance != '0) ? PAYOUT : COLLECT;
        end
      end
      PAYOUT: begin
        w_rej_nxt = w_any_coin;
        if (!w_pace_busy) begin
          if (r_balance != '0) begin
            w_chg_nxt = 1'b1;
            w_bal_nxt = r_balance - BAL_W'(1);
            w_load    = 1'b1;
          end else begin
            w_state_nxt = COLLECT;
          end
        end
      end
      default: begin
        w_state_nxt = COLLECT;
      end
    endcase
  end

  // State and output registers, all cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= COLLECT;
      r_balance  <= '0;
      r_t_rst_n  <= 1'b1;
      r_dispense <= 1'b0;
      r_change   <= 1'b0;
      r_reject   <= 1'b0;
      r_busy     <= 1'b0;
      r_first    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_balance  <= w_bal_nxt;
      r_t_rst_n  <= w_trst_nxt;
      r_dispense <= w_disp_nxt;
      r_change   <= w_chg_nxt;
      r_reject   <= w_rej_nxt;
      r_busy     <= (w_state_nxt != COLLECT);
      r_first    <= w_first_nxt;
    end
  end

  assign t_rst_n      = r_t_rst_n;
  assign dispense     = r_dispense;
  assign change_pulse = r_change;
  assign coin_reject  = r_reject;
  assign balance      = r_balance;
  assign busy         = r_busy;

endmodule

// File: tb/tb_seller_ctrl.sv
// Directed bench for seller_ctrl with a behavioural dispense timer.
// Table vectors cover collection; hand sequences cover dispense, refund, reset.
// A second instance with MAX_BAL=5 exercises the overflow reject.
module tb_seller_ctrl;

  localparam int PRICE     = 5;
  localparam int MAX_BAL   = 15;
  localparam int BAL_W     = 4;
  localparam int GAP       = 3;
  localparam int PULSE_CNT = 10;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             coin_half = 1'b0, coin_one = 1'b0, cancel = 1'b0;
  logic             t_end;
  logic             t_rst_n, dispense, change_pulse, coin_reject, busy;
  logic [BAL_W-1:0] balance;

  logic             b_coin_half = 1'b0, b_coin_one = 1'b0, b_cancel = 1'b0;
  logic             b_t_rst_n, b_dispense, b_change_pulse, b_coin_reject, b_busy;
  logic [BAL_W-1:0] b_balance;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seller_ctrl #(.PRICE(PRICE), .MAX_BAL(MAX_BAL), .BAL_W(BAL_W), .GAP(GAP)) u_dut (
    .clk(clk), .rst_n(rst_n), .coin_half(coin_half), .coin_one(coin_one),
    .cancel(cancel), .t_end(t_end), .t_rst_n(t_rst_n), .dispense(dispense),
    .change_pulse(change_pulse), .coin_reject(coin_reject), .balance(balance),
    .busy(busy)
  );

  seller_ctrl #(.PRICE(5), .MAX_BAL(5), .BAL_W(BAL_W), .GAP(GAP)) u_dut_small (
    .clk(clk), .rst_n(rst_n), .coin_half(b_coin_half), .coin_one(b_coin_one),
    .cancel(b_cancel), .t_end(1'b0), .t_rst_n(b_t_rst_n), .dispense(b_dispense),
    .change_pulse(b_change_pulse), .coin_reject(b_coin_reject), .balance(b_balance),
    .busy(b_busy)
  );

  // Timer model: counts while t_rst_n is low, pulses t_end on the PULSE_CNT-th cycle.
  logic [3:0] tm_cnt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tm_cnt <= 4'd0;
      t_end  <= 1'b0;
    end else if (t_rst_n) begin
      tm_cnt <= 4'd0;
      t_end  <= 1'b0;
    end else if (tm_cnt == 4'(PULSE_CNT - 1)) begin
      tm_cnt <= 4'd0;
      t_end  <= 1'b1;
    end else begin
      tm_cnt <= tm_cnt + 4'd1;
      t_end  <= 1'b0;
    end
  end

  // Monitors: cycle stamp, change pulse log, dispense and timer-run occupancy.
  int cyc = 0;
  int chg_total = 0;
  int disp_total = 0;
  int trst_low_total = 0;
  int stamp [8];
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (change_pulse) begin
      stamp[chg_total % 8] = cyc;
      chg_total = chg_total + 1;
    end
    if (dispense) disp_total = disp_total + 1;
    if (!t_rst_n) trst_low_total = trst_low_total + 1;
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Apply one cycle of inputs to the main instance; returns at the next negedge.
  task automatic step(input logic h, input logic o, input logic c);
    coin_half = h; coin_one = o; cancel = c;
    @(negedge clk);
    coin_half = 1'b0; coin_one = 1'b0; cancel = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int max_cyc);
    int n;
    n = 0;
    while (busy && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    check({name, "_idle"}, int'(busy), 0);
    #1;
  endtask

  typedef struct {
    logic h;
    logic o;
    logic c;
    int   bal;
    logic rej;
    logic bsy;
    logic disp;
    logic trst;
  } vec_t;

  vec_t vecs [10];

  initial begin
    int base, dbase, tbase, dcount;

    // Cancel with nothing inserted, then five half coins with idle gaps.
    vecs[0] = '{1'b0, 1'b0, 1'b1, 0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[1] = '{1'b1, 1'b0, 1'b0, 1, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[2] = '{1'b0, 1'b0, 1'b0, 1, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{1'b1, 1'b0, 1'b0, 2, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{1'b0, 1'b0, 1'b0, 2, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[5] = '{1'b1, 1'b0, 1'b0, 3, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[6] = '{1'b0, 1'b0, 1'b0, 3, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[7] = '{1'b1, 1'b0, 1'b0, 4, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[8] = '{1'b0, 1'b0, 1'b0, 4, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[9] = '{1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b1, 1'b0};

    // Reset and release.
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_trst", int'(t_rst_n), 1);
    check("rst_disp", int'(dispense), 0);
    check("rst_chg", int'(change_pulse), 0);
    check("rst_rej", int'(coin_reject), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_bal", int'(balance), 0);

    // Table: collection up to the price.
    #1 base = chg_total;
    for (int i = 0; i < 10; i++) begin
      step(vecs[i].h, vecs[i].o, vecs[i].c);
      check($sformatf("vec%0d_bal", i), int'(balance), vecs[i].bal);
      check($sformatf("vec%0d_rej", i), int'(coin_reject), int'(vecs[i].rej));
      check($sformatf("vec%0d_busy", i), int'(busy), int'(vecs[i].bsy));
      check($sformatf("vec%0d_disp", i), int'(dispense), int'(vecs[i].disp));
      check($sformatf("vec%0d_trst", i), int'(t_rst_n), int'(vecs[i].trst));
    end

    // Dispense length with an exact price: 11 cycles, then back to COLLECT.
    dcount = 1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (!dispense) break;
      dcount++;
    end
    check("exact_disp_len", dcount, 11);
    #1;
    check("exact_busy", int'(busy), 0);
    check("exact_bal", int'(balance), 0);
    check("exact_trst", int'(t_rst_n), 1);
    check("exact_no_change", chg_total - base, 0);

    // Three 1-yuan coins: dispense with one unit of change.
    base = chg_total;
    step(1'b0, 1'b1, 1'b0);
    check("c3_bal1", int'(balance), 2);
    step(1'b0, 1'b1, 1'b0);
    check("c3_bal2", int'(balance), 4);
    step(1'b0, 1'b1, 1'b0);
    check("c3_bal_change", int'(balance), 1);
    check("c3_disp", int'(dispense), 1);
    wait_idle("c3", 60);
    check("c3_changes", chg_total - base, 1);
    check("c3_bal_end", int'(balance), 0);

    // Refund of 3 units, with a coin refused mid-payout.
    @(negedge clk);
    #1 base = chg_total; dbase = disp_total; tbase = trst_low_total;
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    check("rf_bal", int'(balance), 3);
    step(1'b0, 1'b0, 1'b1);
    check("rf_busy", int'(busy), 1);
    check("rf_bal_hold", int'(balance), 3);
    step(1'b0, 1'b1, 1'b0);
    check("rf_reject", int'(coin_reject), 1);
    check("rf_bal_after_reject", int'(balance), 2);
    wait_idle("rf", 40);
    check("rf_changes", chg_total - base, 3);
    check("rf_gap1", stamp[(base + 1) % 8] - stamp[base % 8], GAP);
    check("rf_gap2", stamp[(base + 2) % 8] - stamp[(base + 1) % 8], GAP);
    check("rf_no_disp", disp_total - dbase, 0);
    check("rf_trst_high", trst_low_total - tbase, 0);

    // Coin during DISPENSE is refused and leaves the balance alone.
    @(negedge clk);
    #1 base = chg_total;
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    check("dr_disp", int'(dispense), 1);
    step(1'b1, 1'b0, 1'b0);
    check("dr_reject", int'(coin_reject), 1);
    check("dr_bal", int'(balance), 0);
    step(1'b0, 1'b0, 1'b0);
    check("dr_reject_clear", int'(coin_reject), 0);
    wait_idle("dr", 40);
    check("dr_no_change", chg_total - base, 0);

    // Overflow on the MAX_BAL=5 instance: balance 4 + 2 is refused.
    for (int k = 0; k < 4; k++) begin
      b_coin_half = 1'b1;
      @(negedge clk);
      b_coin_half = 1'b0;
    end
    check("ov_bal4", int'(b_balance), 4);
    b_coin_one = 1'b1;
    @(negedge clk);
    b_coin_one = 1'b0;
    check("ov_reject", int'(b_coin_reject), 1);
    check("ov_bal_hold", int'(b_balance), 4);
    check("ov_busy", int'(b_busy), 0);
    check("ov_disp", int'(b_dispense), 0);
    check("ov_trst", int'(b_t_rst_n), 1);
    check("ov_chg", int'(b_change_pulse), 0);

    // Reset between the first and second pulse of a 3-unit refund.
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    dcount = 0;
    while (!change_pulse && dcount < 10) begin
      @(negedge clk);
      dcount++;
    end
    check("rr_first_pulse", int'(change_pulse), 1);
    check("rr_bal_before", int'(balance), 2);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rr_bal", int'(balance), 0);
    check("rr_busy", int'(busy), 0);
    check("rr_chg", int'(change_pulse), 0);
    check("rr_trst", int'(t_rst_n), 1);
    base = chg_total;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (15) @(negedge clk);
    #1;
    check("rr_no_more_pulses", chg_total - base, 0);
    check("rr_bal_end", int'(balance), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
